// File: rtl/multi_mode_row_adc.sv
// multi_mode_row_adc: single-slope row ADC back-end with optional CDS reset/signal ramps
module multi_mode_row_adc #(
  parameter int NUM_PIXELS = 20,
  parameter int CNT_WIDTH  = 8,
  parameter int RAMP_MAX   = 2**CNT_WIDTH-1,
  parameter int RST_MAX    = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            cds_mode,
  input  logic [NUM_PIXELS-1:0]           comp,
  output logic                            ramp_en,
  output logic                            ramp_phase,
  output logic                            busy,
  output logic                            valid,
  output logic [NUM_PIXELS*CNT_WIDTH-1:0] pixel_data,
  output logic [NUM_PIXELS-1:0]           ovf
);
  typedef enum logic [1:0] {IDLE, RAMP_RST, RAMP_SIG, DONE} state_t;
  state_t                          state_q;
  logic [CNT_WIDTH-1:0]            cnt_q, ph_max;
  logic                            cds_q, last;
  logic [NUM_PIXELS-1:0]           prev_q, cap_q, rst_ovf_q, hit, miss, ovf_q;
  logic [CNT_WIDTH-1:0]            code_q [NUM_PIXELS];
  logic [CNT_WIDTH-1:0]            rst_code_q [NUM_PIXELS];
  logic [CNT_WIDTH-1:0]            code_d [NUM_PIXELS];
  logic [NUM_PIXELS*CNT_WIDTH-1:0] res_d, data_q;
  logic                            ramp_en_q, ramp_phase_q, busy_q, valid_q;
  assign ramp_en    = ramp_en_q;
  assign ramp_phase = ramp_phase_q;
  assign busy       = busy_q;
  assign valid      = valid_q;
  assign pixel_data = data_q;
  assign ovf        = ovf_q;
  // code_d is the phase code as it stands after this cycle; at phase end misses already hold ph_max
  always_comb begin
    ph_max = state_q == RAMP_RST ? CNT_WIDTH'(RST_MAX) : CNT_WIDTH'(RAMP_MAX);
    last   = cnt_q == ph_max;
    hit    = comp & ~prev_q & ~cap_q;
    miss   = ~(cap_q | hit);
    res_d  = '0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      code_d[i] = cap_q[i] ? code_q[i] : hit[i] ? cnt_q : ph_max;
      res_d[i*CNT_WIDTH +: CNT_WIDTH] = !cds_q ? code_d[i] :
        code_d[i] >= rst_code_q[i] ? code_d[i] - rst_code_q[i] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cds_q        <= 1'b0;
      prev_q       <= '0;
      cap_q        <= '0;
      rst_ovf_q    <= '0;
      ovf_q        <= '0;
      data_q       <= '0;
      ramp_en_q    <= 1'b0;
      ramp_phase_q <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      for (int i = 0; i < NUM_PIXELS; i++) begin
        code_q[i]     <= '0;
        rst_code_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q      <= cds_mode ? RAMP_RST : RAMP_SIG;
          cds_q        <= cds_mode;
          cnt_q        <= '0;
          prev_q       <= '0;
          cap_q        <= '0;
          rst_ovf_q    <= '0;
          ramp_en_q    <= 1'b1;
          ramp_phase_q <= cds_mode;
          busy_q       <= 1'b1;
          for (int i = 0; i < NUM_PIXELS; i++) begin
            code_q[i]     <= '0;
            rst_code_q[i] <= '0;
          end
        end
        RAMP_RST, RAMP_SIG: if (last) begin
          cnt_q  <= '0;
          prev_q <= '0;
          cap_q  <= '0;
          if (state_q == RAMP_RST) begin
            state_q      <= RAMP_SIG;
            rst_ovf_q    <= miss;
            ramp_phase_q <= 1'b0;
            rst_code_q   <= code_d;
          end else begin
            state_q   <= DONE;
            ramp_en_q <= 1'b0;
            valid_q   <= 1'b1;
            data_q    <= res_d;
            ovf_q     <= miss | (cds_q ? rst_ovf_q : '0);
          end
        end else begin
          cnt_q  <= cnt_q + 1'b1;
          prev_q <= comp;
          cap_q  <= cap_q | hit;
          code_q <= code_d;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multi_mode_row_adc.sv
// tb_multi_mode_row_adc: randomized and directed checks of the row ADC against a first-edge model
module tb_multi_mode_row_adc;
  localparam int N = 4, W = 8, RM = 255, RS = 15;
  logic clk = 0, reset = 1, start = 0, cds_mode = 0;
  logic [N-1:0] comp = '0;
  logic ramp_en, ramp_phase, busy, valid;
  logic [N*W-1:0] pixel_data;
  logic [N-1:0] ovf;
  logic s_start = 0, s_comp = 0, s_en, s_ph, s_busy, s_valid, s_ovf;
  logic [3:0] s_data;
  int total = 0, bad = 0;
  bit wr [N][RM+1];
  bit ws [N][RM+1];
  int exp_d [N];
  bit exp_o [N];

  always #5 clk = ~clk;

  multi_mode_row_adc #(.NUM_PIXELS(N), .CNT_WIDTH(W), .RAMP_MAX(RM), .RST_MAX(RS)) dut (
    .clk(clk), .reset(reset), .start(start), .cds_mode(cds_mode), .comp(comp),
    .ramp_en(ramp_en), .ramp_phase(ramp_phase), .busy(busy), .valid(valid),
    .pixel_data(pixel_data), .ovf(ovf));

  multi_mode_row_adc #(.NUM_PIXELS(1), .CNT_WIDTH(4), .RAMP_MAX(9), .RST_MAX(3)) sdut (
    .clk(clk), .reset(reset), .start(s_start), .cds_mode(1'b0), .comp(s_comp),
    .ramp_en(s_en), .ramp_phase(s_ph), .busy(s_busy), .valid(s_valid),
    .pixel_data(s_data), .ovf(s_ovf));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_sig(input int p, input int at);
    for (int c = 0; c <= RM; c++) ws[p][c] = at >= 0 && c >= at;
  endtask

  task automatic set_rst(input int p, input int at);
    for (int c = 0; c <= RM; c++) wr[p][c] = at >= 0 && c >= at && c <= RS;
  endtask

  task automatic rand_waves();
    for (int p = 0; p < N; p++) begin
      int ts = $urandom_range(0, RM + 30), tr = $urandom_range(0, RS + 6);
      set_sig(p, ts);
      set_rst(p, tr);
      if ($urandom_range(0, 3) == 0) ws[p][$urandom_range(0, RM)] = 1'b1;
      if ($urandom_range(0, 3) == 0 && ts <= RM) ws[p][$urandom_range(ts, RM)] = 1'b0;
    end
  endtask

  // first high sample in a phase is the captured edge; none means overflow at full scale
  task automatic model(input bit cds);
    for (int p = 0; p < N; p++) begin
      int s = RM, r = RS;
      bit so = 1, ro = 1;
      for (int c = RM; c >= 0; c--) if (ws[p][c]) begin s = c; so = 0; end
      for (int c = RS; c >= 0; c--) if (wr[p][c]) begin r = c; ro = 0; end
      exp_d[p] = !cds ? s : (s > r ? s - r : 0);
      exp_o[p] = so | (cds & ro);
    end
  endtask

  task automatic run(input bit cds, input bit hold);
    int rlen = cds ? RS + 1 : 0, errs = 0;
    model(cds);
    if (busy !== 1'b0 || valid !== 1'b0) errs++;
    start = 1'b1;
    cds_mode = cds;
    for (int k = 1; k <= rlen + RM + 1; k++) begin
      @(posedge clk); #1;
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      cds_mode = 1'($urandom_range(0, 1));
      for (int p = 0; p < N; p++) comp[p] = k <= rlen ? wr[p][k-1] : ws[p][k-1-rlen];
      if (busy !== 1'b1 || ramp_en !== 1'b1 || valid !== 1'b0 || ramp_phase !== 1'(k <= rlen)) errs++;
    end
    @(posedge clk); #1;
    comp = N'($urandom);
    if (valid !== 1'b1 || busy !== 1'b1 || ramp_en !== 1'b0 || ramp_phase !== 1'b0) errs++;
    for (int p = 0; p < N; p++) begin
      chk($sformatf("data%0d", p), pixel_data[p*W +: W], exp_d[p]);
      chk($sformatf("ovf%0d", p), ovf[p], exp_o[p]);
    end
    @(posedge clk); #1;
    start = hold;
    if (valid !== 1'b0 || busy !== 1'b0 || ramp_en !== 1'b0) errs++;
    for (int p = 0; p < N; p++) chk($sformatf("hold%0d", p), pixel_data[p*W +: W], exp_d[p]);
    chk(cds ? "seq_cds" : "seq", errs, 0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out", {pixel_data, ovf, busy, valid, ramp_en, ramp_phase}, 0);
    @(posedge clk); #1;
    set_sig(0, 10); set_sig(1, 100); set_sig(2, 200); set_sig(3, 255);
    run(0, 0);
    set_sig(0, 0); set_sig(1, -1); set_sig(2, 50); set_sig(3, 77);
    for (int c = 60; c < 70; c++) ws[2][c] = 1'b0;
    run(0, 0);
    set_rst(0, 5); set_rst(1, 12); set_rst(2, -1); set_rst(3, 0);
    set_sig(0, 105); set_sig(1, 8); set_sig(2, 40); set_sig(3, 0);
    run(1, 0);
    rand_waves(); run(0, 1);
    rand_waves(); run(1, 1);
    rand_waves(); run(1, 0);
    repeat (6) begin
      rand_waves();
      run(1'($urandom_range(0, 1)), 0);
    end
    start = 1'b1;
    cds_mode = 1'b0;
    for (int k = 1; k <= 121; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      comp = N'($urandom);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort", {pixel_data, ovf, busy, valid, ramp_en, ramp_phase}, 0);
    @(posedge clk); #1;
    chk("abort_idle", {busy, valid}, 0);
    rand_waves(); run(0, 0);
    s_comp = 1'b0;
    for (int t = 0; t < 2; t++) begin
      s_start = 1'b1;
      cyc = 0;
      while (s_valid !== 1'b1 && cyc < 30) begin
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc++;
        s_comp = t == 1 && cyc == 10;
      end
      chk("s_lat", cyc, 11);
      chk("s_data", s_data, 9);
      chk("s_ovf", s_ovf, t == 0);
      @(posedge clk); #1;
      s_comp = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_mode_row_adc.md
Name: multi_mode_row_adc

Overview:
- Next-generation single-slope row ADC back-end for one pixel row: parametrised pixel count and counter width.
- Adds an explicit start/valid conversion handshake, ramp-length control and overflow flags for pixels that never trip.
- Adds an optional correlated-double-sampling (CDS) mode: a reset-level ramp followed by a signal-level ramp, with per-pixel digital subtraction.
- Sits between the per-column comparators and the row readout/side-channel capture logic; drives the ramp generator enable.

Parameters:
- NUM_PIXELS, 20, number of comparator inputs / output codes.
- CNT_WIDTH, 8, counter and output code width.
- RAMP_MAX, 2**CNT_WIDTH-1, final count of the signal ramp (inclusive); must be < 2**CNT_WIDTH.
- RST_MAX, 15, final count of the CDS reset ramp (inclusive); must be <= RAMP_MAX.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- cds_mode  input  1  sampled with start: 0 = single ramp, 1 = CDS.
- comp  input  NUM_PIXELS  comparator outputs, already synchronous to clk.
- ramp_en  output  1  high while any ramp phase is active.
- ramp_phase  output  1  0 = signal ramp, 1 = reset ramp; 0 when ramp_en=0.
- busy  output  1  high in every state except IDLE.
- valid  output  1  one-cycle pulse, pixel_data/ovf are new.
- pixel_data  output  NUM_PIXELS x CNT_WIDTH  per-pixel conversion result.
- ovf  output  NUM_PIXELS  per-pixel overflow (no comparator edge in a phase).

Behaviour:
- Reset: state=IDLE, counter=0, all capture/flag regs=0, ramp_en=0, ramp_phase=0, busy=0, valid=0, pixel_data=0, ovf=0. Reset in any state aborts the conversion with no valid pulse.
- FSM states: IDLE, RAMP_RST, RAMP_SIG, DONE.
- IDLE:
  - start=1 latches cds_mode and clears counter, comp_prev, captured flags and phase codes.
  - Next state is RAMP_RST if cds_mode=1, otherwise RAMP_SIG.
  - start is ignored in all other states; a held start triggers only one conversion per IDLE visit.
- Ramp phases:
  - counter starts at 0 and increments by 1 each cycle.
  - The phase ends after the cycle with counter==RAMP_MAX (RAMP_SIG) or counter==RST_MAX (RAMP_RST); counter never wraps.
  - RAMP_RST goes to RAMP_SIG, with counter, comp_prev and captured flags cleared on the transition.
  - RAMP_SIG goes to DONE.
- Capture:
  - In a ramp cycle with counter=c, pixel i captures c when comp[i]=1, comp_prev[i]=0 and captured[i]=0. Only the first edge per phase counts.
  - comp_prev <= comp every ramp cycle. Because comp_prev is cleared on phase entry, a comparator already high in the first phase cycle captures 0.
  - A later fall/rise of comp in the same phase is ignored.
- Missing edge: at phase end, an uncaptured pixel takes code = phase max (RAMP_MAX or RST_MAX) and its overflow bit is set. Overflow from either phase sets ovf[i].
- Result, loaded on the RAMP_SIG->DONE transition:
  - cds=0: pixel_data[i] = sig_code[i].
  - cds=1: pixel_data[i] = sig_code[i] - rst_code[i], saturated at 0 when negative, CNT_WIDTH wide.
- DONE: lasts one cycle with valid=1, then IDLE. pixel_data/ovf hold until the next DONE or reset.
- Outputs:
  - busy=1 in RAMP_RST, RAMP_SIG and DONE.
  - ramp_en=1 in RAMP_RST and RAMP_SIG.
  - ramp_phase=1 in RAMP_RST only.
- Latency, with the start cycle as cycle 0:
  - Normal mode: RAMP_SIG covers cycles 1..RAMP_MAX+1; valid in cycle RAMP_MAX+2.
  - CDS: RAMP_RST covers cycles 1..RST_MAX+1; RAMP_SIG covers RST_MAX+2..RST_MAX+RAMP_MAX+2; valid in cycle RST_MAX+RAMP_MAX+3.

Test Plan:
- Basic conversion (NUM_PIXELS=4, CNT_WIDTH=8, RAMP_MAX=255, RST_MAX=15), cds=0:
  - Stimulus: comp rises at counter 10, 100, 200 and 255; start at cycle 0.
  - Required: valid only at cycle 257; pixel_data={10,100,200,255}; ovf=0.
- Overflow and edge cases, cds=0:
  - Stimulus: pixel0 high from the first ramp cycle; pixel1 never rises; pixel2 rises at 50, falls at 60, rises at 70.
  - Required: pixel_data0=0; pixel_data1=255 with ovf1=1; pixel_data2=50.
- CDS mode:
  - Stimulus: reset-ramp edges at 5, 12 and none; signal-ramp edges at 105, 8 and 40.
  - Required: ramp_phase=1 for cycles 1..16; valid at cycle 273; pixel_data={100,0 (saturated),25}; ovf={0,0,1}.
- Handshake:
  - Stimulus: start held high continuously.
  - Required: back-to-back conversions, each separated by one IDLE cycle; start pulses during busy cause no extra or shortened conversion; busy/ramp_en waveforms as specified.
- Reset mid-operation:
  - Stimulus: reset asserted at counter 120 of RAMP_SIG.
  - Required: next cycle shows all outputs 0 (including previous pixel_data) with no valid pulse; a fresh start then converts correctly.
- Parameter sweep:
  - Stimulus: NUM_PIXELS=1, CNT_WIDTH=4, RAMP_MAX=9.
  - Required: counter stops at 9 without wrap; untriggered pixel gives pixel_data=9 with ovf=1; valid at cycle 11.
